// File: rtl/pe_array_dispatcher.sv
// pe_array_dispatcher
// Queues host instructions and issues them one at a time to the PE array,
// either broadcast or to a single PE, holding the array busy for a fixed
// execute window. Host register readbacks are serialised against execution
// through a single pending slot. Instructions always win over readback.
//
// Handshakes: start and rd_req are single-cycle strobes with no ready return.
// start is accepted on any edge where the queue is not full. rd_req lands in the
// pending slot unless a readback is already on the wire. pe_issue, rb_en and
// rd_valid are one-cycle strobes, and their payloads are stable while the
// strobe is high. pe_instr/pe_sel/pe_bcast and data hold until the next update.
module pe_array_dispatcher #(
  parameter int SIZE        = 5,
  parameter int LENGTH      = 32,
  parameter int DATA_W      = 16,
  parameter int REG_AW      = 10,
  parameter int FIFO_DEPTH  = 4,
  parameter int EXEC_CYCLES = 4
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [LENGTH-1:0] instruction,
  input  logic              start,
  input  logic              bcast,
  input  logic [SIZE-1:0]   PE_Addr,
  input  logic [REG_AW-1:0] RegAddr,
  input  logic              rd_req,
  output logic              full,
  output logic              overflow,
  output logic              busy,
  output logic              pe_issue,
  output logic [LENGTH-1:0] pe_instr,
  output logic [SIZE-1:0]   pe_sel,
  output logic              pe_bcast,
  input  logic              pe_stall,
  output logic              rb_en,
  output logic [SIZE-1:0]   rb_pe,
  output logic [REG_AW-1:0] rb_reg,
  input  logic [DATA_W-1:0] rb_data,
  output logic [DATA_W-1:0] data,
  output logic              rd_valid,
  output logic [15:0]       issued_cnt,
  output logic [2:0]        dbg_state
);

  // The opcode sits at instruction[LENGTH-1 -: 6]. It is carried unchanged;
  // only the array decodes it.
  localparam int PTR_W   = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int CNT_W   = PTR_W + 1;
  localparam int ENTRY_W = 1 + SIZE + LENGTH;
  localparam int EC_W    = (EXEC_CYCLES > 1) ? $clog2(EXEC_CYCLES) : 1;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_ISSUE   = 3'd1,
    ST_EXEC    = 3'd2,
    ST_RB_REQ  = 3'd3,
    ST_RB_WAIT = 3'd4
  } state_t;

  state_t              state_q;
  logic [EC_W-1:0]     exec_cnt_q;

  logic [ENTRY_W-1:0]  fifo_q [FIFO_DEPTH];
  logic [PTR_W-1:0]    wr_ptr_q, rd_ptr_q;
  logic [CNT_W-1:0]    count_q, count_d;
  logic                push, pop, full_w;
  logic [ENTRY_W-1:0]  head_w;

  logic                rb_pend_q;
  logic [SIZE-1:0]     slot_pe_q;
  logic [REG_AW-1:0]   slot_reg_q;
  logic                rd_accept;

  logic                overflow_q, busy_q, pe_issue_q, pe_bcast_q;
  logic [LENGTH-1:0]   pe_instr_q;
  logic [SIZE-1:0]     pe_sel_q;
  logic                rb_en_q, rd_valid_q;
  logic [SIZE-1:0]     rb_pe_q;
  logic [REG_AW-1:0]   rb_reg_q;
  logic [DATA_W-1:0]   data_q;
  logic [15:0]         issued_cnt_q;

  assign full_w    = (count_q == CNT_W'(FIFO_DEPTH));
  assign push      = start && !full_w;
  // ISSUE is only ever entered with a non-empty queue, so the pop is safe.
  assign pop       = (state_q == ST_ISSUE);
  assign head_w    = fifo_q[rd_ptr_q];
  // Once the readback is on the wire the slot is frozen until it completes.
  assign rd_accept = rd_req && (state_q != ST_RB_REQ) && (state_q != ST_RB_WAIT);

  // Queue occupancy next-state: simultaneous push and pop cancel out.
  always_comb begin
    count_d = count_q;
    case ({push, pop})
      2'b10:   count_d = count_q + CNT_W'(1);
      2'b01:   count_d = count_q - CNT_W'(1);
      default: count_d = count_q;
    endcase
  end

  // Queue storage: payload only, pointers carry validity.
  always_ff @(posedge clk) begin
    if (push) fifo_q[wr_ptr_q] <= {bcast, PE_Addr, instruction};
  end

  // Queue pointers, occupancy and the sticky overflow flag.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
      overflow_q <= 1'b0;
    end else begin
      if (push) wr_ptr_q <= wr_ptr_q + PTR_W'(1);
      if (pop)  rd_ptr_q <= rd_ptr_q + PTR_W'(1);
      count_q <= count_d;
      if (start && full_w) overflow_q <= 1'b1;
    end
  end

  // Pending readback slot: last accepted request wins, cleared on completion.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      rb_pend_q  <= 1'b0;
      slot_pe_q  <= '0;
      slot_reg_q <= '0;
    end else if (state_q == ST_RB_WAIT) begin
      rb_pend_q <= 1'b0;
    end else if (rd_accept) begin
      rb_pend_q  <= 1'b1;
      slot_pe_q  <= PE_Addr;
      slot_reg_q <= RegAddr;
    end
  end

  // Dispatch FSM with registered strobes and held payload outputs.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q      <= ST_IDLE;
      exec_cnt_q   <= '0;
      busy_q       <= 1'b0;
      pe_issue_q   <= 1'b0;
      pe_instr_q   <= '0;
      pe_sel_q     <= '0;
      pe_bcast_q   <= 1'b0;
      issued_cnt_q <= '0;
      rb_en_q      <= 1'b0;
      rb_pe_q      <= '0;
      rb_reg_q     <= '0;
      data_q       <= '0;
      rd_valid_q   <= 1'b0;
    end else begin
      pe_issue_q <= 1'b0;
      rb_en_q    <= 1'b0;
      rd_valid_q <= 1'b0;
      busy_q     <= (state_q != ST_IDLE) || (count_q != '0);
      case (state_q)
        ST_IDLE: begin
          if (count_q != '0) begin
            state_q <= ST_ISSUE;
          end else if (rb_pend_q) begin
            // rb_en is high for exactly the RB_REQ cycle; a same-edge
            // overwrite of the slot is honoured.
            state_q  <= ST_RB_REQ;
            rb_en_q  <= 1'b1;
            rb_pe_q  <= rd_accept ? PE_Addr : slot_pe_q;
            rb_reg_q <= rd_accept ? RegAddr : slot_reg_q;
          end
        end
        ST_ISSUE: begin
          pe_issue_q   <= 1'b1;
          pe_instr_q   <= head_w[LENGTH-1:0];
          pe_sel_q     <= head_w[LENGTH+SIZE-1:LENGTH];
          pe_bcast_q   <= head_w[ENTRY_W-1];
          issued_cnt_q <= issued_cnt_q + 16'd1;
          exec_cnt_q   <= EC_W'(EXEC_CYCLES - 1);
          state_q      <= ST_EXEC;
        end
        ST_EXEC: begin
          if (!pe_stall) begin
            if (exec_cnt_q == '0) state_q <= ST_IDLE;
            else                  exec_cnt_q <= exec_cnt_q - EC_W'(1);
          end
        end
        ST_RB_REQ: begin
          state_q <= ST_RB_WAIT;
        end
        ST_RB_WAIT: begin
          data_q     <= rb_data;
          rd_valid_q <= 1'b1;
          state_q    <= ST_IDLE;
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  assign full       = full_w;
  assign overflow   = overflow_q;
  assign busy       = busy_q;
  assign pe_issue   = pe_issue_q;
  assign pe_instr   = pe_instr_q;
  assign pe_sel     = pe_sel_q;
  assign pe_bcast   = pe_bcast_q;
  assign rb_en      = rb_en_q;
  assign rb_pe      = rb_pe_q;
  assign rb_reg     = rb_reg_q;
  assign data       = data_q;
  assign rd_valid   = rd_valid_q;
  assign issued_cnt = issued_cnt_q;
  assign dbg_state  = state_q;

endmodule

// File: tb/tb_pe_array_dispatcher.sv
// Bench for pe_array_dispatcher: directed scenarios plus a randomized run
// scored against an instruction-queue / readback model.
module tb_pe_array_dispatcher;
  localparam int SIZE = 5, LENGTH = 32, DATA_W = 16, REG_AW = 10;
  localparam int DEPTH = 4, EXEC = 4;

  // ---------------- clock / reset / signals ----------------
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic              reset = 1'b0;
  logic [LENGTH-1:0] instruction = '0;
  logic              start = 1'b0, bcast = 1'b0, rd_req = 1'b0, pe_stall = 1'b0;
  logic [SIZE-1:0]   PE_Addr = '0;
  logic [REG_AW-1:0] RegAddr = '0;
  logic [DATA_W-1:0] rb_data = '0;
  logic              full, overflow, busy, pe_issue, pe_bcast, rb_en, rd_valid;
  logic [LENGTH-1:0] pe_instr;
  logic [SIZE-1:0]   pe_sel, rb_pe;
  logic [REG_AW-1:0] rb_reg;
  logic [DATA_W-1:0] data;
  logic [15:0]       issued_cnt;
  logic [2:0]        dbg_state;

  int errors = 0;
  int checks = 0;

  pe_array_dispatcher #(
    .SIZE(SIZE), .LENGTH(LENGTH), .DATA_W(DATA_W), .REG_AW(REG_AW),
    .FIFO_DEPTH(DEPTH), .EXEC_CYCLES(EXEC)
  ) dut (
    .clk(clk), .reset(reset), .instruction(instruction), .start(start),
    .bcast(bcast), .PE_Addr(PE_Addr), .RegAddr(RegAddr), .rd_req(rd_req),
    .full(full), .overflow(overflow), .busy(busy), .pe_issue(pe_issue),
    .pe_instr(pe_instr), .pe_sel(pe_sel), .pe_bcast(pe_bcast),
    .pe_stall(pe_stall), .rb_en(rb_en), .rb_pe(rb_pe), .rb_reg(rb_reg),
    .rb_data(rb_data), .data(data), .rd_valid(rd_valid),
    .issued_cnt(issued_cnt), .dbg_state(dbg_state)
  );

  // ---------------- array readback model ----------------
  logic              rb_fixed = 1'b0;
  logic              prev_rb_en = 1'b0;
  logic [SIZE-1:0]   prev_rb_pe = '0;
  logic [REG_AW-1:0] prev_rb_reg = '0;

  function automatic logic [15:0] rb_hash(input logic [4:0] pe, input logic [9:0] r);
    return {1'b1, pe, r} ^ 16'h5A3C;
  endfunction

  // One clock step; the array answers a strobe with data in the next cycle.
  task automatic tick();
    @(posedge clk);
    #1;
    rb_data     = prev_rb_en ? (rb_fixed ? 16'hBEEF : rb_hash(prev_rb_pe, prev_rb_reg)) : '0;
    prev_rb_en  = rb_en;
    prev_rb_pe  = rb_pe;
    prev_rb_reg = rb_reg;
  endtask

  task automatic apply_reset();
    start = 0; rd_req = 0; pe_stall = 0; bcast = 0;
    instruction = '0; PE_Addr = '0; RegAddr = '0;
    reset = 1'b0;
    repeat (3) tick();
    reset = 1'b1;
    tick();
  endtask

  task automatic wait_idle(input string name);
    int t;
    t = 0;
    while (busy && t < 100) begin tick(); t++; end
    checks++;
    if (busy !== 1'b0) begin errors++; $display("FAIL %s_idle_timeout: busy=%0b required 0", name, busy); end
  endtask

  // ---------------- scenarios ----------------
  task automatic test_reset();
    apply_reset();
    checks++;
    if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %0b required 0", busy); end
    checks++;
    if (full !== 1'b0) begin errors++; $display("FAIL reset_full: got %0b required 0", full); end
    checks++;
    if ({overflow, pe_issue, pe_instr, pe_sel, pe_bcast, rb_en, rb_pe, rb_reg, data, rd_valid, issued_cnt} !== '0) begin
      errors++;
      $display("FAIL reset_outputs: got ovf=%0b iss=%0b instr=%0h sel=%0h bc=%0b rb_en=%0b rb_pe=%0h rb_reg=%0h data=%0h rdv=%0b cnt=%0d required all 0",
               overflow, pe_issue, pe_instr, pe_sel, pe_bcast, rb_en, rb_pe, rb_reg, data, rd_valid, issued_cnt);
    end
    checks++;
    if (dbg_state !== 3'd0) begin errors++; $display("FAIL reset_state: got %0d required 0", dbg_state); end
  endtask

  task automatic test_single_issue();
    instruction = 32'h1C221800; bcast = 1'b1; PE_Addr = '0; start = 1'b1;
    tick();
    start = 1'b0; bcast = 1'b0;
    for (int k = 0; k < 3; k++) begin
      if (k > 0) tick();
      checks++;
      if (pe_issue !== (k == 2)) begin errors++; $display("FAIL single_issue_timing: cycle+%0d got %0b required %0b", k, pe_issue, (k == 2)); end
    end
    checks++;
    if (pe_instr !== 32'h1C221800) begin errors++; $display("FAIL single_instr: got %0h required 1c221800", pe_instr); end
    checks++;
    if (pe_bcast !== 1'b1) begin errors++; $display("FAIL single_bcast: got %0b required 1", pe_bcast); end
    checks++;
    if (issued_cnt !== 16'd1) begin errors++; $display("FAIL single_cnt: got %0d required 1", issued_cnt); end
    for (int k = 1; k <= EXEC + 1; k++) begin
      tick();
      checks++;
      if (busy !== (k <= EXEC)) begin errors++; $display("FAIL single_busy: issue+%0d got %0b required %0b", k, busy, (k <= EXEC)); end
    end
    checks++;
    if (pe_instr !== 32'h1C221800) begin errors++; $display("FAIL single_instr_held: got %0h required 1c221800", pe_instr); end
  endtask

  task automatic test_stall_delay();
    int t;
    int gap;
    instruction = 32'h0000_AAAA; PE_Addr = 5'd7; start = 1'b1;
    tick();
    instruction = 32'h0000_BBBB; PE_Addr = 5'd9;
    tick();
    start = 1'b0;
    t = 0;
    while (!pe_issue && t < 10) begin tick(); t++; end
    checks++;
    if (pe_instr !== 32'h0000_AAAA || pe_issue !== 1'b1) begin errors++; $display("FAIL stall_first: got iss=%0b instr=%0h required 1/0000aaaa", pe_issue, pe_instr); end
    pe_stall = 1'b1;
    repeat (3) tick();
    pe_stall = 1'b0;
    gap = 3;
    while (!pe_issue && gap < 40) begin tick(); gap++; end
    checks++;
    if (gap !== EXEC + 2 + 3) begin errors++; $display("FAIL stall_gap: got %0d required %0d", gap, EXEC + 5); end
    checks++;
    if (pe_instr !== 32'h0000_BBBB || pe_sel !== 5'd9) begin errors++; $display("FAIL stall_second: got instr=%0h sel=%0h required 0000bbbb/9", pe_instr, pe_sel); end
    wait_idle("stall");
  endtask

  // Queue is filled while the array is frozen in an execute window, so no pop
  // can make room; afterwards the four accepted entries drain back to back.
  task automatic test_overflow_back_to_back();
    int t;
    int n;
    int ts[8];
    instruction = 32'h5555_0000; PE_Addr = 5'd3; start = 1'b1;
    tick();
    start = 1'b0;
    t = 0;
    while (!pe_issue && t < 10) begin tick(); t++; end
    pe_stall = 1'b1;
    for (int i = 0; i < 5; i++) begin
      instruction = 32'hA000_0000 + i; PE_Addr = 5'(i); bcast = 1'(i); start = 1'b1;
      tick();
      checks++;
      if (full !== (i >= 3)) begin errors++; $display("FAIL ovf_full: entry %0d got %0b required %0b", i, full, (i >= 3)); end
      checks++;
      if (overflow !== (i == 4)) begin errors++; $display("FAIL ovf_flag: entry %0d got %0b required %0b", i, overflow, (i == 4)); end
    end
    start = 1'b0; bcast = 1'b0; pe_stall = 1'b0;
    n = 0;
    for (int c = 0; c < 80; c++) begin
      tick();
      if (pe_issue) begin
        if (n < 4) begin
          ts[n] = c;
          checks++;
          if (pe_instr !== 32'hA000_0000 + n || pe_sel !== 5'(n) || pe_bcast !== 1'(n)) begin
            errors++;
            $display("FAIL b2b_order: issue %0d got instr=%0h sel=%0h bc=%0b required %0h/%0h/%0b", n, pe_instr, pe_sel, pe_bcast, 32'hA000_0000 + n, n, n & 1);
          end
        end
        n++;
      end
    end
    checks++;
    if (n !== 4) begin errors++; $display("FAIL b2b_count: got %0d issues required 4", n); end
    for (int i = 1; i < 4; i++) begin
      if (i < n) begin
        checks++;
        if (ts[i] - ts[i-1] !== EXEC + 2) begin errors++; $display("FAIL b2b_spacing: gap %0d got %0d required %0d", i, ts[i] - ts[i-1], EXEC + 2); end
      end
    end
    checks++;
    if (full !== 1'b0 || overflow !== 1'b1) begin errors++; $display("FAIL b2b_flags: got full=%0b ovf=%0b required 0/1", full, overflow); end
    wait_idle("b2b");
  endtask

  task automatic test_readback();
    PE_Addr = 5'h11; RegAddr = 10'h020; rd_req = 1'b1; rb_fixed = 1'b1;
    tick();
    rd_req = 1'b0;
    checks++;
    if (rb_en !== 1'b0) begin errors++; $display("FAIL rb_en_early: got %0b required 0", rb_en); end
    tick();
    checks++;
    if (rb_en !== 1'b1 || rb_pe !== 5'h11 || rb_reg !== 10'h020) begin
      errors++; $display("FAIL rb_strobe: got en=%0b pe=%0h reg=%0h required 1/11/020", rb_en, rb_pe, rb_reg);
    end
    tick();
    checks++;
    if (rb_en !== 1'b0 || rd_valid !== 1'b0) begin errors++; $display("FAIL rb_wait: got en=%0b rdv=%0b required 0/0", rb_en, rd_valid); end
    tick();
    checks++;
    if (rd_valid !== 1'b1 || data !== 16'hBEEF) begin errors++; $display("FAIL rb_data: got rdv=%0b data=%0h required 1/beef", rd_valid, data); end
    tick();
    checks++;
    if (rd_valid !== 1'b0 || data !== 16'hBEEF) begin errors++; $display("FAIL rb_hold: got rdv=%0b data=%0h required 0/beef", rd_valid, data); end
    rb_fixed = 1'b0;
  endtask

  task automatic test_random();
    logic [SIZE+LENGTH:0] exp_q[$];
    logic [SIZE+LENGTH:0] ent;
    logic [15:0]          rb_exp;
    logic                 pend, movf, s_r, r_r, acc;
    logic [SIZE-1:0]      rq_pe;
    logic [REG_AW-1:0]    rq_reg;
    logic [15:0]          miss;
    int                   mcnt;
    apply_reset();
    pend = 0; movf = 0; miss = '0; mcnt = 0; rb_exp = '0;
    for (int c = 0; c < 600; c++) begin
      s_r         = (c < 400) && ($urandom_range(0, 2) == 0);
      r_r         = (c < 400) && !pend && ($urandom_range(0, 7) == 0);
      pe_stall    = (c < 400) && ($urandom_range(0, 3) == 0);
      start       = s_r;
      rd_req      = r_r;
      bcast       = 1'($urandom_range(0, 1));
      PE_Addr     = 5'($urandom_range(0, 31));
      RegAddr     = 10'($urandom_range(0, 1023));
      instruction = $urandom();
      ent         = {bcast, PE_Addr, instruction};
      rq_pe       = PE_Addr;
      rq_reg      = RegAddr;
      acc         = s_r && (mcnt < DEPTH);
      tick();
      if (pe_issue) begin
        checks++;
        if (exp_q.size() == 0) begin
          errors++; $display("FAIL rnd_issue: cycle %0d unexpected issue instr=%0h", c, pe_instr);
        end else begin
          if ({pe_bcast, pe_sel, pe_instr} !== exp_q[0]) begin
            errors++; $display("FAIL rnd_issue: cycle %0d got %0h required %0h", c, {pe_bcast, pe_sel, pe_instr}, exp_q[0]);
          end
          void'(exp_q.pop_front());
          mcnt--;
          miss++;
        end
      end
      if (acc) begin exp_q.push_back(ent); mcnt++; end
      else if (s_r) movf = 1'b1;
      checks++;
      if (full !== (mcnt == DEPTH)) begin errors++; $display("FAIL rnd_full: cycle %0d got %0b required %0b", c, full, (mcnt == DEPTH)); end
      checks++;
      if (overflow !== movf) begin errors++; $display("FAIL rnd_overflow: cycle %0d got %0b required %0b", c, overflow, movf); end
      checks++;
      if (issued_cnt !== miss) begin errors++; $display("FAIL rnd_cnt: cycle %0d got %0d required %0d", c, issued_cnt, miss); end
      if (rd_valid) begin
        checks++;
        if (!pend || data !== rb_exp) begin
          errors++; $display("FAIL rnd_readback: cycle %0d got data=%0h pend=%0b required %0h", c, data, pend, rb_exp);
        end
        pend = 1'b0;
      end
      if (r_r) begin pend = 1'b1; rb_exp = rb_hash(rq_pe, rq_reg); end
    end
    checks++;
    if (exp_q.size() != 0 || pend) begin errors++; $display("FAIL rnd_drain: got %0d queued, pend=%0b required 0/0", exp_q.size(), pend); end
    checks++;
    if (busy !== 1'b0) begin errors++; $display("FAIL rnd_busy: got %0b required 0", busy); end
  endtask

  task automatic test_reset_mid_exec();
    int rdv_n;
    int iss_n;
    int busy_n;
    instruction = 32'h1111_0001; PE_Addr = 5'd1; start = 1'b1;
    tick();
    instruction = 32'h1111_0002; PE_Addr = 5'd2;
    tick();
    start = 1'b0; rd_req = 1'b1; PE_Addr = 5'd4; RegAddr = 10'h3FF;
    tick();
    rd_req = 1'b0;
    checks++;
    if (pe_issue !== 1'b1) begin errors++; $display("FAIL rst_pre_issue: got %0b required 1", pe_issue); end
    tick();
    tick();
    reset = 1'b0;
    #1;
    checks++;
    if (issued_cnt !== 16'd0) begin errors++; $display("FAIL rst_cnt: got %0d required 0", issued_cnt); end
    checks++;
    if (full !== 1'b0 || busy !== 1'b0 || pe_issue !== 1'b0 || dbg_state !== 3'd0) begin
      errors++; $display("FAIL rst_async: got full=%0b busy=%0b iss=%0b st=%0d required 0/0/0/0", full, busy, pe_issue, dbg_state);
    end
    tick();
    reset = 1'b1;
    rdv_n = 0; iss_n = 0; busy_n = 0;
    for (int c = 0; c < 20; c++) begin
      tick();
      if (rd_valid) rdv_n++;
      if (pe_issue) iss_n++;
      if (busy) busy_n++;
    end
    checks++;
    if (rdv_n !== 0) begin errors++; $display("FAIL rst_no_rdvalid: got %0d pulses required 0", rdv_n); end
    checks++;
    if (iss_n !== 0 || busy_n !== 0) begin errors++; $display("FAIL rst_queue_empty: got %0d issues, %0d busy cycles required 0/0", iss_n, busy_n); end
  endtask

  // ---------------- sequence and report ----------------
  initial begin
    test_reset();
    test_single_issue();
    test_stall_delay();
    test_overflow_back_to_back();
    test_readback();
    test_random();
    test_reset_mid_exec();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
